// File: rtl/serial_and16.sv
// Bit-serial bitwise AND: one operand bit pair per cycle, LSB first, with a
// valid/ready handshake on both the operand side and the result side.
module serial_and16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand and result shift registers; all hold outside the capture and shift states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         cnt  <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
         end else if (state == SHIFT) begin
            res  <= {a_sh[0] & b_sh[0], res[WIDTH-1:1]};
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            // Wrap on the final shift so the counter never exceeds WIDTH-1.
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         end
      end
   end

   // Outputs are decoded from the registered state only, never from handshake inputs.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);
   assign c         = res;

endmodule

// File: tb/tb_serial_and16.sv
// Scoreboard bench for serial_and16: stimulus pushes expected results and
// accept times; a monitor checks latency and data whenever a result appears.
module tb_serial_and16;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] c;
   logic         busy;

   serial_and16 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [W-1:0] exp_q[$];
   int unsigned  acc_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
   endtask

   // Monitor: latency on the rising edge of out_valid, data at each handshake.
   logic         prev_ov = 1'b0;
   logic [W-1:0] mon_exp;
   int unsigned  mon_acc;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               mon_acc = acc_q.pop_front();
               chk("latency", cyc - mon_acc, W);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", {16'd0, c}, 32'hDEAD);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("result_c", {16'd0, c}, {16'd0, mon_exp});
            end
         end
         prev_ov = out_valid;
      end
   end

   // Present a pair until accepted; returns just after the accepting edge.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ex, input bit hold_valid,
                       output int unsigned acc_cyc);
      int t = 0;
      a = av;
      b = bv;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("send_timeout", 32'd1, 32'd0);
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
      acc_cyc = cyc;
      if (!hold_valid) in_valid = 1'b0;
   endtask

   // Wait for out_valid, confirming in_ready stays low and busy high meanwhile.
   task automatic wait_result(input string nm);
      int t = 0;
      int bad = 0;
      while (!out_valid && t < 64) begin
         if (in_ready || !busy) bad++;
         @(negedge clk);
         t++;
      end
      chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_in_ready_low"}, bad, 32'd0);
   endtask

   int unsigned acc;
   int unsigned prev_acc;
   int          bad;
   logic [W-1:0] ra;
   logic [W-1:0] rb;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_c", {16'd0, c}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single-cycle in_valid pulse right after reset release.
      send(16'hFFFF, 16'hA5A5, 16'hA5A5, 1'b0, acc);
      wait_result("t032");
      @(posedge clk); #1;

      // Consumer stalls for several cycles in DONE.
      out_ready = 1'b0;
      send(16'h0F0F, 16'h3C3C, 16'h0C0C, 1'b0, acc);
      wait_result("t033");
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (!out_valid || c !== 16'h0C0C) bad++;
         @(negedge clk);
      end
      chk("t033_stable", bad, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t033_idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t033_idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset in the middle of SHIFT discards the pending result.
      send(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, acc);
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      exp_q.delete();
      acc_q.delete();
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_c", {16'd0, c}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      bad = 0;
      repeat (24) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      chk("abort_no_out_valid", bad, 32'd0);
      @(posedge clk); #1;
      send(16'h1234, 16'hFFFF, 16'h1234, 1'b0, acc);
      wait_result("t034");
      @(posedge clk); #1;

      // Operands toggled during SHIFT must be ignored.
      send(16'h8001, 16'h8001, 16'h8001, 1'b0, acc);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         a = 16'($urandom);
         b = 16'($urandom);
         @(negedge clk);
         if (in_ready || !busy) bad++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("t035_ignored", bad, 32'd0);
      wait_result("t035");
      @(posedge clk); #1;

      // All-zero and all-one operand corners.
      send(16'h0000, 16'hFFFF, 16'h0000, 1'b0, acc);
      wait_result("t037a");
      @(posedge clk); #1;
      send(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, acc);
      wait_result("t037b");
      @(posedge clk); #1;

      // Back-to-back with in_valid and out_ready held high.
      bad = 0;
      prev_acc = 0;
      for (int i = 0; i < 100; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         send(ra, rb, ra & rb, 1'b1, acc);
         if (i > 0 && (acc - prev_acc) != W + 2) bad++;
         prev_acc = acc;
      end
      in_valid = 1'b0;
      chk("t036_period", bad, 32'd0);

      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
      @(posedge clk); #1;
      chk("drain_exp_q", exp_q.size(), 32'd0);
      chk("drain_acc_q", acc_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
